// File: rtl/spad_fill_arbiter.sv
// -----------------------------------------------------------------------------
// spad_fill_arbiter
//
// Shares one first-word-fall-through input FIFO (fed from the global buffer)
// among NUM_REQ PE scratchpads. Requesters are served one at a time in
// round-robin order. Each granted burst streams burst_len words from the FIFO
// into the owning scratchpad and then pulses done. If the owner drops its
// request while the burst is in progress, the burst is cut short and abort
// pulses instead.
//
// Optional feature, enabled by defining SPAD_ARB_TIMEOUT_EN:
//   a stall counter aborts a burst after TIMEOUT consecutive en-high cycles in
//   which the FIFO stayed empty. Without the macro, the arbiter waits on an
//   empty FIFO indefinitely.
//
// Ports
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset
//   en          global advance; when low, nothing moves and nothing is written
//   req         per-requester fill request (level, held until done/abort)
//   burst_len   per-requester word count, slice i = [i*ADDR_W +: ADDR_W]
//   fifo_empty  shared FIFO empty flag
//   fifo_dout   FIFO head word
//   fifo_rd_en  pop the FIFO head this cycle
//   spad_wdata  scratchpad write data (pass-through of fifo_dout)
//   spad_we     one-hot write enable to the owning scratchpad
//   spad_waddr  shared scratchpad write address
//   grant       one-hot current owner, zero while idle
//   busy        high whenever a burst is in progress
//   done        one-cycle one-hot pulse on burst completion
//   abort       one-cycle one-hot pulse on early burst termination
// -----------------------------------------------------------------------------
module spad_fill_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] burst_len,
  input  logic                      fifo_empty,
  input  logic [DATA_WIDTH-1:0]     fifo_dout,
  output logic                      fifo_rd_en,
  output logic [DATA_WIDTH-1:0]     spad_wdata,
  output logic [NUM_REQ-1:0]        spad_we,
  output logic [ADDR_W-1:0]         spad_waddr,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        abort
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_XFER, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]  len_q, len_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   last_ptr_q, last_ptr_d;

  logic [NUM_REQ-1:0] owner_oh;
  logic [ADDR_W-1:0]  last_idx;
  logic [PTR_W-1:0]   pick;
  logic               pick_vld;
  logic               stall_abort;

  assign owner_oh   = NUM_REQ'(1) << owner_q;
  assign last_idx   = len_q - ADDR_W'(1);
  assign spad_wdata = fifo_dout;
  assign spad_waddr = cnt_q;
  assign busy       = (state_q != S_IDLE);

  // Round-robin pick: walk the distances 1..NUM_REQ from the last owner and
  // take the first requester found. Both loops unroll to constant indices.
  // NOTE: every variable written in an always_comb gets a default before any
  // branch, otherwise a path that skips the assignment infers a latch.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!pick_vld && req[j] &&
            ((int'(last_ptr_q) + i == j) || (int'(last_ptr_q) + i == j + NUM_REQ))) begin
          pick     = PTR_W'(j);
          pick_vld = 1'b1;
        end
      end
    end
  end

`ifdef SPAD_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_q;

  // Fires on the TIMEOUT-th consecutive stall cycle itself, so the counter
  // holds the number of stall cycles seen before the current one.
  assign stall_abort = (state_q == S_XFER) && en && fifo_empty &&
                       (stall_q == STALL_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if (state_q != S_XFER) begin
      stall_q <= '0;
    end else if (en) begin
      stall_q <= fifo_empty ? stall_q + STALL_W'(1) : '0;
    end
  end
`else
  assign stall_abort = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    owner_d    = owner_q;
    last_ptr_d = last_ptr_q;
    fifo_rd_en = 1'b0;
    spad_we    = '0;
    grant      = (state_q == S_IDLE) ? '0 : owner_oh;
    done       = '0;
    abort      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (en && pick_vld) begin
          owner_d = pick;
          len_d   = burst_len[pick*ADDR_W +: ADDR_W];
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (en) begin
          cnt_d = '0;
          if (!req[owner_q]) begin
            abort      = owner_oh;
            last_ptr_d = owner_q;
            state_d    = S_IDLE;
          end else if (len_q == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_XFER;
          end
        end
      end
      S_XFER: begin
        if (en) begin
          // A dropped request beats a write in the same cycle, including the
          // final one, so an aborted burst never gets its last word.
          if (!req[owner_q] || stall_abort) begin
            abort      = owner_oh;
            last_ptr_d = owner_q;
            state_d    = S_IDLE;
          end else if (!fifo_empty) begin
            fifo_rd_en = 1'b1;
            spad_we    = owner_oh;
            cnt_d      = cnt_q + ADDR_W'(1);
            if (cnt_q == last_idx) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (en) begin
          done       = owner_oh;
          last_ptr_d = owner_q;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: only control registers exist here; all of them reset so outputs are
  // defined immediately after reset. last_ptr resets to the top index so that
  // requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      owner_q    <= '0;
      last_ptr_q <= PTR_W'(NUM_REQ - 1);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      owner_q    <= owner_d;
      last_ptr_q <= last_ptr_d;
    end
  end

endmodule
